// File: rtl/ddr_serializer_tx_if.sv
// Word-input handshake bundle for ddr_serializer_tx: valid/ready plus the
// parallel word carrying LANES lanes of RATIO bits each.
interface ddr_serializer_tx_if #(
  parameter int LANES = 4,
  parameter int RATIO = 8
);
  logic                     s_valid;
  logic                     s_ready;
  logic [LANES*RATIO-1:0]   s_data;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/ddr_serializer_tx.sv
// Multi-lane DDR transmit serializer: input word FIFO, per-lane rising/falling
// register pair, DDR output mux. Define DDR_TX_TRAINING_EN to add the training pattern.
module ddr_serializer_tx #(
  parameter int   LANES      = 4,
  parameter int   RATIO      = 8,
  parameter int   FIFO_DEPTH = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ddr_serializer_tx_if.slave          s_if,
  output logic [LANES-1:0]            data_r,
  output logic [LANES-1:0]            data_f,
  output logic [LANES-1:0]            dout,
  output logic                        word_start,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        underflow,
  input  logic                        underflow_clr
`ifdef DDR_TX_TRAINING_EN
  ,
  input  logic                        train_en
`endif
);

  localparam int WW   = LANES * RATIO;
  localparam int HALF = RATIO / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
`ifdef DDR_TX_TRAINING_EN
    ,
    ST_TRAIN = 2'd2
`endif
  } state_e;

  state_e            state_q, state_d, state_base_s;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WW-1:0]     word_q, word_d;
  logic [LANES-1:0]  data_r_q, data_r_d;
  logic [LANES-1:0]  data_f_q, data_f_d;
  logic              word_start_q, word_start_d;
  logic              underflow_q, underflow_d;

  logic [WW-1:0]     mem_q [FIFO_DEPTH];
  logic [WW-1:0]     mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;

  logic              s_ready_s;
  logic              wr_s;
  logic              pop_s;
  logic              fifo_ne_s;
  logic              eow_s;
  logic              uf_set_s;
  logic [WW-1:0]     head_s;
  logic [WW-1:0]     head_shr_s;
  logic [WW-1:0]     word_shr_s;
  logic [LANES-1:0]  head_r_s, head_f_s;
  logic [LANES-1:0]  word_r_s, word_f_s;

  assign s_ready_s   = (level_q < LW'(FIFO_DEPTH));
  assign s_if.s_ready = s_ready_s;
  assign wr_s        = s_if.s_valid && s_ready_s;
  assign fifo_ne_s   = (level_q != LW'(0));
  assign eow_s       = (state_q == ST_SHIFT) && (cnt_q == CW'(HALF - 1));
  assign head_s      = mem_q[rd_ptr_q];

  // Each lane sends its slice LSB first, so bits 0/1 of the slice are the next pair.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign head_r_s[k] = head_s[k*RATIO];
    assign head_f_s[k] = head_s[k*RATIO+1];
    assign word_r_s[k] = word_q[k*RATIO];
    assign word_f_s[k] = word_q[k*RATIO+1];
    assign head_shr_s[k*RATIO +: RATIO] = head_s[k*RATIO +: RATIO] >> 2'd2;
    assign word_shr_s[k*RATIO +: RATIO] = word_q[k*RATIO +: RATIO] >> 2'd2;
  end

  // Next-state logic; training overrides only at word boundaries or from idle.
  always_comb begin
    case (state_q)
      ST_IDLE:  state_base_s = fifo_ne_s ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: state_base_s = (!eow_s || fifo_ne_s) ? ST_SHIFT : ST_IDLE;
`ifdef DDR_TX_TRAINING_EN
      ST_TRAIN: state_base_s = fifo_ne_s ? ST_SHIFT : ST_IDLE;
`endif
      default:  state_base_s = ST_IDLE;
    endcase
`ifdef DDR_TX_TRAINING_EN
    state_d = (train_en && (state_q != ST_SHIFT || eow_s)) ? ST_TRAIN : state_base_s;
`else
    state_d = state_base_s;
`endif
  end

  // Output/datapath logic: pop on every entry into a new word.
  always_comb begin
    pop_s        = (state_d == ST_SHIFT) && ((state_q != ST_SHIFT) || eow_s);
    cnt_d        = cnt_q;
    word_d       = word_q;
    data_r_d     = {LANES{IDLE_LEVEL}};
    data_f_d     = {LANES{IDLE_LEVEL}};
    word_start_d = 1'b0;
    if (pop_s) begin
      cnt_d        = CW'(0);
      word_d       = head_shr_s;
      data_r_d     = head_r_s;
      data_f_d     = head_f_s;
      word_start_d = 1'b1;
    end else if (state_d == ST_SHIFT) begin
      cnt_d    = cnt_q + CW'(1);
      word_d   = word_shr_s;
      data_r_d = word_r_s;
      data_f_d = word_f_s;
`ifdef DDR_TX_TRAINING_EN
    end else if (state_d == ST_TRAIN) begin
      cnt_d    = CW'(0);
      data_r_d = {LANES{1'b1}};
      data_f_d = {LANES{1'b0}};
`endif
    end else begin
      cnt_d = CW'(0);
    end

    // A write landing on the very edge the stream drains means the producer was late.
    uf_set_s = eow_s && (state_d == ST_IDLE) && wr_s;
    if (uf_set_s) begin
      underflow_d = 1'b1;
    end else if (underflow_clr) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  // FIFO pointer and occupancy update.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_s) begin
      mem_d[wr_ptr_q] = s_if.s_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and FIFO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= CW'(0);
      word_q       <= '0;
      data_r_q     <= {LANES{IDLE_LEVEL}};
      data_f_q     <= {LANES{IDLE_LEVEL}};
      word_start_q <= 1'b0;
      underflow_q  <= 1'b0;
      wr_ptr_q     <= AW'(0);
      rd_ptr_q     <= AW'(0);
      level_q      <= LW'(0);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      data_r_q     <= data_r_d;
      data_f_q     <= data_f_d;
      word_start_q <= word_start_d;
      underflow_q  <= underflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      mem_q        <= mem_d;
    end
  end

  // Only the pin mux sees the low phase; it maps onto the vendor ODDR cell.
  assign dout       = clk ? data_r_q : data_f_q;
  assign data_r     = data_r_q;
  assign data_f     = data_f_q;
  assign word_start = word_start_q;
  assign underflow  = underflow_q;
  assign level      = level_q;
  assign busy       = (state_q != ST_IDLE) || fifo_ne_s;

endmodule
